// File: rtl/demux_1x8_ctrl_pkg.sv
// Shared constants, FSM state type and wait-counter sizing for the 1-to-8 routing controller.
package demux_1x8_ctrl_pkg;

  localparam int N_DEST = 8;
  localparam int DEST_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // The counter must be able to hold the value TIMEOUT itself.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/demux_1x8_ctrl_demux.sv
// Combinational 1-to-8 demultiplexer: routes 'in' to the output addressed by 's', all others low.
module demux_1x8
  import demux_1x8_ctrl_pkg::*;
(
  input  logic              in,
  input  logic [DEST_W-1:0] s,
  output logic              y0,
  output logic              y1,
  output logic              y2,
  output logic              y3,
  output logic              y4,
  output logic              y5,
  output logic              y6,
  output logic              y7
);

  assign y0 = in && (s == 3'd0);
  assign y1 = in && (s == 3'd1);
  assign y2 = in && (s == 3'd2);
  assign y3 = in && (s == 3'd3);
  assign y4 = in && (s == 3'd4);
  assign y5 = in && (s == 3'd5);
  assign y6 = in && (s == 3'd6);
  assign y7 = in && (s == 3'd7);

endmodule

// File: rtl/demux_1x8_ctrl.sv
// Valid/ready routing controller: registers one item + destination, presents it one-hot until taken.
// out_valid 1 cycle after accept; optional hold timeout via DEMUX_1X8_CTRL_TIMEOUT_EN.
module demux_1x8_ctrl
  import demux_1x8_ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DEST_W-1:0] in_dest,
  output logic [N_DEST-1:0] out_valid,
  input  logic [N_DEST-1:0] out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DEST_W-1:0] sel,
  output logic              busy,
  output logic              drop
);

  state_t              r_state;
  logic [DATA_W-1:0]   r_data;
  logic [DEST_W-1:0]   r_sel;

  logic w_busy;
  logic w_take;
  logic w_acc;
  logic w_drop;

  assign w_busy   = (r_state == SEND);
  assign w_take   = w_busy && out_ready[r_sel];
  // Ready depends combinationally on the addressed consumer so a transfer and a new accept share a cycle.
  assign in_ready = !w_busy || w_take;
  assign w_acc    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_sel   <= '0;
    end else if (w_acc) begin
      r_state <= SEND;
      r_data  <= in_data;
      r_sel   <= in_dest;
    end else if (w_take || w_drop) begin
      r_state <= IDLE;
    end
  end

`ifdef DEMUX_1X8_CTRL_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;
  logic             w_stall;

  assign w_stall = w_busy && !out_ready[r_sel];
  // A transfer in the expiry cycle wins, so drop is qualified by the stall.
  assign w_drop  = w_stall && (r_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_acc) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != CNT_W'(TIMEOUT))) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  assign w_drop = 1'b0;
`endif

  assign busy     = w_busy;
  assign drop     = w_drop;
  assign sel      = r_sel;
  assign out_data = r_data;

  demux_1x8 u_demux (
    .in (w_busy),
    .s  (r_sel),
    .y0 (out_valid[0]),
    .y1 (out_valid[1]),
    .y2 (out_valid[2]),
    .y3 (out_valid[3]),
    .y4 (out_valid[4]),
    .y5 (out_valid[5]),
    .y6 (out_valid[6]),
    .y7 (out_valid[7])
  );

endmodule

// File: tb/tb_demux_1x8_ctrl.sv
// Directed vector bench for demux_1x8_ctrl: table-driven routing plus reset and hold/timeout sequences.
module tb_demux_1x8_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_dest;
  logic [7:0] out_valid;
  logic [7:0] out_ready;
  logic [7:0] out_data;
  logic [2:0] sel;
  logic       busy;
  logic       drop;

  int n_cmp;
  int n_err;
  int n_drop;

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic [2:0] dest;
    logic [7:0] ordy;
    logic [7:0] exp_ov;
    logic       exp_irdy;
    logic       exp_busy;
    logic [2:0] exp_sel;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[20];

  demux_1x8_ctrl #(.DATA_W(8), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel),
    .busy      (busy),
    .drop      (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    n_drop = 0;

    //            vld data   dest  ordy    ov     irdy busy sel   odata
    tbl[0]  = '{1'b0, 8'h00, 3'd0, 8'hFF, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[1]  = '{1'b1, 8'hA5, 3'd5, 8'hFF, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[2]  = '{1'b0, 8'h00, 3'd0, 8'hFF, 8'h20, 1'b1, 1'b1, 3'd5, 8'hA5};
    tbl[3]  = '{1'b0, 8'h00, 3'd0, 8'hFF, 8'h00, 1'b1, 1'b0, 3'd5, 8'hA5};
    tbl[4]  = '{1'b1, 8'h11, 3'd0, 8'hFF, 8'h00, 1'b1, 1'b0, 3'd5, 8'hA5};
    tbl[5]  = '{1'b1, 8'h22, 3'd7, 8'hFF, 8'h01, 1'b1, 1'b1, 3'd0, 8'h11};
    tbl[6]  = '{1'b1, 8'h33, 3'd3, 8'hFF, 8'h80, 1'b1, 1'b1, 3'd7, 8'h22};
    tbl[7]  = '{1'b0, 8'h00, 3'd0, 8'hFF, 8'h08, 1'b1, 1'b1, 3'd3, 8'h33};
    tbl[8]  = '{1'b0, 8'h00, 3'd0, 8'hFF, 8'h00, 1'b1, 1'b0, 3'd3, 8'h33};
    tbl[9]  = '{1'b1, 8'h5C, 3'd2, 8'hFB, 8'h00, 1'b1, 1'b0, 3'd3, 8'h33};
    tbl[10] = '{1'b1, 8'h77, 3'd1, 8'hFB, 8'h04, 1'b0, 1'b1, 3'd2, 8'h5C};
    tbl[11] = '{1'b1, 8'h77, 3'd1, 8'hFB, 8'h04, 1'b0, 1'b1, 3'd2, 8'h5C};
    tbl[12] = '{1'b1, 8'h77, 3'd1, 8'hFB, 8'h04, 1'b0, 1'b1, 3'd2, 8'h5C};
    tbl[13] = '{1'b1, 8'h77, 3'd1, 8'hFB, 8'h04, 1'b0, 1'b1, 3'd2, 8'h5C};
    tbl[14] = '{1'b0, 8'h00, 3'd0, 8'h04, 8'h04, 1'b1, 1'b1, 3'd2, 8'h5C};
    tbl[15] = '{1'b0, 8'h00, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2, 8'h5C};
    tbl[16] = '{1'b1, 8'hC3, 3'd4, 8'hEF, 8'h00, 1'b1, 1'b0, 3'd2, 8'h5C};
    tbl[17] = '{1'b0, 8'h00, 3'd0, 8'hEF, 8'h10, 1'b0, 1'b1, 3'd4, 8'hC3};
    tbl[18] = '{1'b1, 8'h9E, 3'd6, 8'h10, 8'h10, 1'b1, 1'b1, 3'd4, 8'hC3};
    tbl[19] = '{1'b0, 8'h00, 3'd0, 8'h00, 8'h40, 1'b0, 1'b1, 3'd6, 8'h9E};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_dest   = 3'd0;
    out_ready = 8'hFF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h00);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_drop",      32'(drop),      32'h0);
    chk("rst_sel",       32'(sel),       32'h0);
    chk("rst_out_data",  32'(out_data),  32'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      in_valid  = tbl[i].vld;
      in_data   = tbl[i].data;
      in_dest   = tbl[i].dest;
      out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
      chk($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].exp_irdy));
      chk($sformatf("v%0d_busy", i),      32'(busy),      32'(tbl[i].exp_busy));
      chk($sformatf("v%0d_sel", i),       32'(sel),       32'(tbl[i].exp_sel));
      chk($sformatf("v%0d_out_data", i),  32'(out_data),  32'(tbl[i].exp_data));
      chk($sformatf("v%0d_drop", i),      32'(drop),      32'h0);
    end

    // Reset while an item for consumer 6 is still held.
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("mid_pre_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'h00);
    chk("mid_rst_busy",      32'(busy),      32'h0);
    chk("mid_rst_drop",      32'(drop),      32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Hold an item for consumer 6 with every consumer stalled.
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_data   = 8'h66;
    in_dest   = 3'd6;
    out_ready = 8'h00;
    @(negedge clk);
    chk("hold_accept_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (drop === 1'b1) n_drop++;
`ifdef DEMUX_1X8_CTRL_TIMEOUT_EN
      chk($sformatf("to_k%0d_drop", k),      32'(drop),      (k == 16) ? 32'h1 : 32'h0);
      chk($sformatf("to_k%0d_busy", k),      32'(busy),      (k <= 16) ? 32'h1 : 32'h0);
      chk($sformatf("to_k%0d_out_valid", k), 32'(out_valid), (k <= 16) ? 32'h40 : 32'h00);
      chk($sformatf("to_k%0d_in_ready", k),  32'(in_ready),  (k <= 16) ? 32'h0 : 32'h1);
`else
      chk($sformatf("hold_k%0d_drop", k),      32'(drop),      32'h0);
      chk($sformatf("hold_k%0d_busy", k),      32'(busy),      32'h1);
      chk($sformatf("hold_k%0d_out_valid", k), 32'(out_valid), 32'h40);
      chk($sformatf("hold_k%0d_out_data", k),  32'(out_data),  32'h66);
      chk($sformatf("hold_k%0d_in_ready", k),  32'(in_ready),  32'h0);
`endif
      @(posedge clk);
      #1;
    end
`ifdef DEMUX_1X8_CTRL_TIMEOUT_EN
    chk("drop_pulse_count", 32'(n_drop), 32'h1);
`else
    chk("drop_pulse_count", 32'(n_drop), 32'h0);
`endif

    out_ready = 8'hFF;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("release_busy",      32'(busy),      32'h0);
    chk("release_out_valid", 32'(out_valid), 32'h00);
    chk("release_drop",      32'(drop),      32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
